// File: rtl/ones_hist_pkg.sv
// Shared types and default sizing for the ones-count histogram.
// Optional max tracking in the top is enabled by ONES_HIST_MAX_TRACK_EN.
package ones_hist_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 4;
    localparam int unsigned DEF_COUNT_WIDTH = 3;
    localparam int unsigned DEF_BIN_WIDTH   = 8;
    localparam int unsigned DEF_TOTAL_WIDTH = 16;

    typedef enum logic {
        RUN      = 1'b0,
        CLEARING = 1'b1
    } hist_state_e;

endpackage

// File: rtl/ones_hist_bin.sv
// One saturating histogram bin; a clear request wins over an increment.
module ones_hist_bin #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/ones_histogram.sv
// Histogram of upstream ones counts with a one-bin-per-cycle clear sweep.
// Define ONES_HIST_MAX_TRACK_EN to track the largest accepted count on max_count.
module ones_histogram
    import ones_hist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned BIN_WIDTH   = DEF_BIN_WIDTH,
    parameter int unsigned TOTAL_WIDTH = DEF_TOTAL_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   count_valid,
    input  logic [COUNT_WIDTH-1:0] bit_count,
    input  logic                   clear,
    input  logic                   rd_en,
    input  logic [COUNT_WIDTH-1:0] rd_addr,
    output logic [BIN_WIDTH-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [TOTAL_WIDTH-1:0] total,
    output logic                   busy,
    output logic                   err_range,
    output logic                   dropped,
    output logic [COUNT_WIDTH-1:0] max_count
);

    localparam int unsigned            NUM_BINS = DATA_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_IDX  = COUNT_WIDTH'(DATA_WIDTH);

    hist_state_e            state_q, state_d;
    logic [COUNT_WIDTH-1:0] sweep_q, sweep_d;
    logic [TOTAL_WIDTH-1:0] total_q, total_d;
    logic                   err_q, err_d;
    logic                   drop_q, drop_d;
    logic [BIN_WIDTH-1:0]   rd_data_q;
    logic                   rd_valid_q;
    logic                   accept;
    logic                   sweeping;
    logic                   first_sweep;
    logic [BIN_WIDTH-1:0]   bin_val [NUM_BINS];
    logic [BIN_WIDTH-1:0]   rd_mux;

    assign sweeping    = (state_q == CLEARING);
    assign first_sweep = sweeping && (sweep_q == '0);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        total_d = total_q;
        err_d   = err_q;
        drop_d  = drop_q;
        accept  = 1'b0;
        case (state_q)
            RUN: begin
                if (clear) begin
                    state_d = CLEARING;
                    sweep_d = '0;
                    if (count_valid) drop_d = 1'b1;
                end else if (count_valid) begin
                    if (bit_count <= MAX_IDX) accept = 1'b1;
                    else                      err_d  = 1'b1;
                end
            end
            CLEARING: begin
                if (count_valid) drop_d = 1'b1;
                if (sweep_q == MAX_IDX) state_d = RUN;
                else                    sweep_d = sweep_q + COUNT_WIDTH'(1);
            end
        endcase
        if (first_sweep) begin
            total_d = '0;
        end else if (accept && (total_q != '1)) begin
            total_d = total_q + TOTAL_WIDTH'(1);
        end
        if (rd_en && (rd_addr > MAX_IDX)) err_d = 1'b1;
    end

    // Out-of-range addresses match no bin and so read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_BINS; i++) begin
            if (rd_addr == COUNT_WIDTH'(i)) rd_mux = bin_val[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            sweep_q    <= '0;
            total_q    <= '0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            total_q    <= total_d;
            err_q      <= err_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    for (genvar g = 0; g < NUM_BINS; g++) begin : g_bin
        ones_hist_bin #(
            .WIDTH(BIN_WIDTH)
        ) u_bin (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && (bit_count == COUNT_WIDTH'(g))),
            .clr   (sweeping && (sweep_q == COUNT_WIDTH'(g))),
            .value (bin_val[g])
        );
    end

`ifdef ONES_HIST_MAX_TRACK_EN
    logic [COUNT_WIDTH-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (first_sweep) begin
            max_d = '0;
        end else if (accept && (bit_count > max_q)) begin
            max_d = bit_count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) max_q <= '0;
        else       max_q <= max_d;
    end

    assign max_count = max_q;
`else
    assign max_count = '0;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign total     = total_q;
    assign busy      = sweeping;
    assign err_range = err_q;
    assign dropped   = drop_q;

endmodule

// File: tb/tb_ones_histogram.sv
// Self-checking bench for ones_histogram: directed table, corner sequences, random vs model.
module tb_ones_histogram;

    localparam int DW = 4;
    localparam int CW = 3;
    localparam int BW = 8;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          count_valid = 1'b0;
    logic [CW-1:0] bit_count = '0;
    logic          clear = 1'b0;
    logic          rd_en = 1'b0;
    logic [CW-1:0] rd_addr = '0;
    logic [BW-1:0] rd_data;
    logic          rd_valid;
    logic [TW-1:0] total;
    logic          busy;
    logic          err_range;
    logic          dropped;
    logic [CW-1:0] max_count;

    int checks = 0;
    int errors = 0;

    // Reference model: bins as plain integers, sweep position -1 when not clearing.
    int m_bins[DW+1];
    int m_total;
    int m_max;
    int m_sweep;
    bit m_err;
    bit m_drop;
    bit m_rv;
    int m_rd;

    ones_histogram #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW),
        .BIN_WIDTH  (BW),
        .TOTAL_WIDTH(TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_valid(count_valid),
        .bit_count  (bit_count),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .total      (total),
        .busy       (busy),
        .err_range  (err_range),
        .dropped    (dropped),
        .max_count  (max_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_bins[i]) m_bins[i] = 0;
        m_total = 0;
        m_max   = 0;
        m_sweep = -1;
        m_err   = 0;
        m_drop  = 0;
        m_rv    = 0;
        m_rd    = 0;
    endtask

    task automatic model_edge(input bit cv, input int bc, input bit clr, input bit rd, input int ra);
        if (rd) begin
            m_rv = 1;
            m_rd = (ra <= DW) ? m_bins[ra] : 0;
            if (ra > DW) m_err = 1;
        end else begin
            m_rv = 0;
        end
        if (m_sweep < 0) begin
            if (clr) begin
                if (cv) m_drop = 1;
                m_sweep = 0;
            end else if (cv) begin
                if (bc <= DW) begin
                    if (m_bins[bc] < (1 << BW) - 1) m_bins[bc]++;
                    if (m_total < (1 << TW) - 1) m_total++;
                    if (bc > m_max) m_max = bc;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_bins[m_sweep] = 0;
            if (m_sweep == 0) begin
                m_total = 0;
                m_max   = 0;
            end
            if (cv) m_drop = 1;
            m_sweep++;
            if (m_sweep > DW) m_sweep = -1;
        end
    endtask

    task automatic compare_all();
        check("total", total, m_total);
        check("busy", busy, (m_sweep >= 0));
        check("err_range", err_range, m_err);
        check("dropped", dropped, m_drop);
        check("rd_valid", rd_valid, m_rv);
        if (m_rv) check("rd_data", rd_data, m_rd);
`ifdef ONES_HIST_MAX_TRACK_EN
        check("max_count", max_count, m_max);
`else
        check("max_count", max_count, 0);
`endif
    endtask

    task automatic step(input bit cv, input int bc, input bit clr, input bit rd, input int ra);
        @(negedge clk);
        count_valid = cv;
        bit_count   = CW'(bc);
        clear       = clr;
        rd_en       = rd;
        rd_addr     = CW'(ra);
        @(posedge clk);
        model_edge(cv, bc, clr, rd, ra);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        count_valid = 1'b0;
        clear       = 1'b0;
        rd_en       = 1'b0;
        #1;
        model_reset();
        check("reset_total", total, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err_range, 0);
        check("reset_dropped", dropped, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_max", max_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_bin(input int a, input int exp, input string name);
        step(0, 0, 0, 1, a);
        check(name, rd_data, exp);
    endtask

    typedef struct {
        bit cv;
        int bc;
        bit rd;
        int ra;
        int exp_total;
        int exp_rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        model_reset();

        vecs[0]  = '{1, 4, 0, 0, 1, 0};
        vecs[1]  = '{1, 2, 0, 0, 2, 0};
        vecs[2]  = '{1, 2, 0, 0, 3, 0};
        vecs[3]  = '{1, 3, 0, 0, 4, 0};
        vecs[4]  = '{1, 2, 0, 0, 5, 0};
        vecs[5]  = '{1, 0, 0, 0, 6, 0};
        vecs[6]  = '{1, 2, 0, 0, 7, 0};
        vecs[7]  = '{0, 0, 1, 0, 7, 1};
        vecs[8]  = '{0, 0, 1, 1, 7, 0};
        vecs[9]  = '{0, 0, 1, 2, 7, 4};
        vecs[10] = '{0, 0, 1, 3, 7, 1};
        vecs[11] = '{0, 0, 1, 4, 7, 1};

        do_reset();

        // Accept counts of words f,a,5,b,9,0,c then read every bin.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].cv, vecs[i].bc, 0, vecs[i].rd, vecs[i].ra);
            check("tbl_total", total, vecs[i].exp_total);
            if (vecs[i].rd) check("tbl_rd_data", rd_data, vecs[i].exp_rd);
        end
`ifdef ONES_HIST_MAX_TRACK_EN
        check("tbl_max", max_count, 4);
`endif

        // Clear with a sample on the second sweep cycle.
        step(0, 0, 1, 0, 0);
        n = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            n++;
            if (k == 1) step(1, 2, 0, 0, 0);
            else        idle();
        end
        check("clear_busy_len", n, DW + 1);
        check("clear_dropped", dropped, 1);
        check("clear_total", total, 0);
        for (int a = 0; a <= DW; a++) read_bin(a, 0, "clear_bin");

        // Saturation of one bin while total keeps counting.
        for (int i = 0; i < 300; i++) step(1, 3, 0, 0, 0);
        check("sat_total", total, 300);
        read_bin(3, 255, "sat_bin3");

        // Out-of-range count and address.
        step(1, 6, 0, 0, 0);
        check("range_err_count", err_range, 1);
        check("range_total", total, 300);
        read_bin(7, 0, "range_rd_data");
        read_bin(3, 255, "range_bin3");
        read_bin(2, 0, "range_bin2");

        // Read of a bin at the same edge it increments.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0);
        step(1, 2, 0, 1, 2);
        check("rmw_old", rd_data, 4);
        check("rmw_valid", rd_valid, 1);
        idle();
        check("rmw_valid_drop", rd_valid, 0);
        read_bin(2, 5, "rmw_new");

        // Reset in the middle of a sweep.
        step(1, 1, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle();
        check("midclr_busy", busy, 1);
        do_reset();
        idle();
        check("post_reset_busy", busy, 0);
        for (int a = 0; a <= DW; a++) read_bin(a, 0, "post_reset_bin");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit cv, clr, rd;
            int bc, ra;
            cv  = ($urandom_range(0, 1) == 1);
            bc  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, DW)) : int'($urandom_range(0, 7));
            clr = ($urandom_range(0, 29) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            ra  = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, DW)) : int'($urandom_range(0, 7));
            if (i == 300) do_reset();
            step(cv, bc, clr, rd, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
